// File: rtl/vga_display_scheduler.sv
// Raster timing, pixel addressing and screen-mode sequencing for a VGA pixel datapath.
// Qualifiers are one cycle behind the address; syncs are two cycles behind the raster.
module vga_display_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int GAME_X0  = 160,
   parameter int GAME_Y0  = 120,
   parameter int GAME_W   = 320,
   parameter int GAME_H   = 240
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       start_req,
   input  logic       over_req,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       display_area,
   output logic       game_enable,
   output logic       hsync,
   output logic       vsync,
   output logic [1:0] mode,
   output logic       frame_tick,
   output logic       mode_ack
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] V_FB   = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] GX_BEG = 10'(GAME_X0);
   localparam logic [9:0] GX_END = 10'(GAME_X0 + GAME_W);
   localparam logic [9:0] GY_BEG = 10'(GAME_Y0);
   localparam logic [9:0] GY_END = 10'(GAME_Y0 + GAME_H);

   typedef enum logic [1:0] {
      MODE_TITLE = 2'd0,
      MODE_PLAY  = 2'd1,
      MODE_OVER  = 2'd2,
      MODE_BAD   = 2'd3
   } mode_e;

   logic [9:0] h_q, h_d, v_q, v_d;
   logic       display_q, display_d;
   logic       game_q, game_d;
   logic       hs1_q, hs1_d, hs2_q, hs2_d;
   logic       vs1_q, vs1_d, vs2_q, vs2_d;
   logic       pend_start_q, pend_start_d;
   logic       pend_over_q, pend_over_d;
   logic       tick_q, tick_d;
   logic       ack_q, ack_d;
   mode_e      mode_q, mode_d;
   logic       h_wrap, fb, eff_start, eff_over;

   always_comb begin
      h_wrap = (h_q == H_LAST);
      fb     = h_wrap && (v_q == V_FB);
      h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
      v_d    = v_q;
      if (h_wrap) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end

      display_d = (h_q < H_ACT) && (v_q < V_ACT);
      game_d    = (mode_q == MODE_PLAY) && (h_q >= GX_BEG) && (h_q < GX_END)
                  && (v_q >= GY_BEG) && (v_q < GY_END);

      // Syncs are active-low; the second stage lines them up with the colour register.
      hs1_d = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs1_d = !((v_q >= VS_BEG) && (v_q < VS_END));
      hs2_d = hs1_q;
      vs2_d = vs1_q;

      // A request arriving in the boundary cycle itself still counts for that boundary.
      eff_start    = pend_start_q | start_req;
      eff_over     = pend_over_q | over_req;
      pend_start_d = fb ? 1'b0 : eff_start;
      pend_over_d  = fb ? 1'b0 : eff_over;

      mode_d = mode_q;
      if (fb) begin
         case (mode_q)
            MODE_TITLE: if (eff_start) mode_d = MODE_PLAY;
            MODE_PLAY:  if (eff_over)  mode_d = MODE_OVER;
            MODE_OVER:  if (eff_start) mode_d = MODE_TITLE;
            default:    mode_d = MODE_TITLE;
         endcase
      end
      ack_d  = fb && (mode_d != mode_q);
      tick_d = fb;
   end

   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         h_q          <= 10'd0;
         v_q          <= 10'd0;
         display_q    <= 1'b0;
         game_q       <= 1'b0;
         hs1_q        <= 1'b1;
         hs2_q        <= 1'b1;
         vs1_q        <= 1'b1;
         vs2_q        <= 1'b1;
         pend_start_q <= 1'b0;
         pend_over_q  <= 1'b0;
         tick_q       <= 1'b0;
         ack_q        <= 1'b0;
         mode_q       <= MODE_TITLE;
      end else begin
         h_q          <= h_d;
         v_q          <= v_d;
         display_q    <= display_d;
         game_q       <= game_d;
         hs1_q        <= hs1_d;
         hs2_q        <= hs2_d;
         vs1_q        <= vs1_d;
         vs2_q        <= vs2_d;
         pend_start_q <= pend_start_d;
         pend_over_q  <= pend_over_d;
         tick_q       <= tick_d;
         ack_q        <= ack_d;
         mode_q       <= mode_d;
      end
   end

   assign pixel_x      = h_q;
   assign pixel_y      = v_q;
   assign display_area = display_q;
   assign game_enable  = game_q;
   assign hsync        = hs2_q;
   assign vsync        = vs2_q;
   assign mode         = mode_q;
   assign frame_tick   = tick_q;
   assign mode_ack     = ack_q;

endmodule

// File: tb/tb_vga_display_scheduler.sv
// Directed bench: a full-size instance for line timing and a scaled instance
// (80 x 20 raster, 1600-cycle frame) for frame timing and mode sequencing.
module tb_vga_display_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_req = 1'b0;
   logic over_req = 1'b0;

   logic [9:0] s_pixel_x, s_pixel_y, f_pixel_x, f_pixel_y;
   logic       s_display_area, s_game_enable, s_hsync, s_vsync, s_frame_tick, s_mode_ack;
   logic       f_display_area, f_game_enable, f_hsync, f_vsync, f_frame_tick, f_mode_ack;
   logic [1:0] s_mode, f_mode;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   logic vs_prev = 1'b1;
   logic hs_prev = 1'b1;
   logic [31:0] tick_q[$];
   logic [31:0] vfall_q[$];
   logic [31:0] vrise_q[$];
   logic [31:0] hfall_q[$];
   logic [31:0] hrise_q[$];

   always #20 clk = ~clk;

   vga_display_scheduler #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .GAME_X0(16), .GAME_Y0(3), .GAME_W(32), .GAME_H(6)
   ) dut_s (
      .clock_25(clk), .reset(reset), .start_req(start_req), .over_req(over_req),
      .pixel_x(s_pixel_x), .pixel_y(s_pixel_y), .display_area(s_display_area),
      .game_enable(s_game_enable), .hsync(s_hsync), .vsync(s_vsync), .mode(s_mode),
      .frame_tick(s_frame_tick), .mode_ack(s_mode_ack)
   );

   vga_display_scheduler dut_f (
      .clock_25(clk), .reset(reset), .start_req(start_req), .over_req(over_req),
      .pixel_x(f_pixel_x), .pixel_y(f_pixel_y), .display_area(f_display_area),
      .game_enable(f_game_enable), .hsync(f_hsync), .vsync(f_vsync), .mode(f_mode),
      .frame_tick(f_frame_tick), .mode_ack(f_mode_ack)
   );

   // Edge recorder; cyc is stable at the falling clock edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (s_frame_tick) tick_q.push_back(32'(cyc));
         if (s_vsync !== vs_prev) begin
            if (!s_vsync) vfall_q.push_back(32'(cyc));
            else          vrise_q.push_back(32'(cyc));
         end
         if (f_hsync !== hs_prev) begin
            if (!f_hsync) hfall_q.push_back(32'(cyc));
            else          hrise_q.push_back(32'(cyc));
         end
         vs_prev <= s_vsync;
         hs_prev <= f_hsync;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // cyc counts edges since release; the qualifier after edge c describes raster position c-1.
   function automatic logic exp_da_s(input int c);
      int p, h, v;
      p = c - 1; h = p % 80; v = (p / 80) % 20;
      return (h < 64) && (v < 12);
   endfunction

   function automatic logic exp_ge_s(input int c, input logic play);
      int p, h, v;
      p = c - 1; h = p % 80; v = (p / 80) % 20;
      return play && (h >= 16) && (h < 48) && (v >= 3) && (v < 9);
   endfunction

   function automatic logic exp_da_f(input int c);
      int p;
      p = c - 1;
      return ((p % 800) < 640) && (((p / 800) % 525) < 480);
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (s_pixel_x !== 10'd0) begin n_err++; $display("FAIL rst_pixel_x: got %0d expected 0", s_pixel_x); end
      n_vec++; if (s_pixel_y !== 10'd0) begin n_err++; $display("FAIL rst_pixel_y: got %0d expected 0", s_pixel_y); end
      n_vec++; if (s_display_area !== 1'b0) begin n_err++; $display("FAIL rst_display_area: got %b expected 0", s_display_area); end
      n_vec++; if (s_game_enable !== 1'b0) begin n_err++; $display("FAIL rst_game_enable: got %b expected 0", s_game_enable); end
      n_vec++; if (s_hsync !== 1'b1 || f_hsync !== 1'b1) begin n_err++; $display("FAIL rst_hsync: got %b/%b expected 1/1", s_hsync, f_hsync); end
      n_vec++; if (s_vsync !== 1'b1 || f_vsync !== 1'b1) begin n_err++; $display("FAIL rst_vsync: got %b/%b expected 1/1", s_vsync, f_vsync); end
      n_vec++; if (s_mode !== 2'd0) begin n_err++; $display("FAIL rst_mode: got %0d expected 0", s_mode); end
      n_vec++; if (s_frame_tick !== 1'b0 || s_mode_ack !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got tick=%b ack=%b expected 0/0", s_frame_tick, s_mode_ack); end
      reset = 1'b0;
      cyc = 0;
      mon_en = 1'b1;
      step();
      n_vec++; if (s_pixel_x !== 10'd1 || f_pixel_x !== 10'd1) begin n_err++; $display("FAIL first_count: got %0d/%0d expected 1/1", s_pixel_x, f_pixel_x); end
   endtask

   task automatic test_line_timing();
      int bad = 0;
      int first_bad = -1;
      while (cyc < 1500) begin
         step();
         if (f_display_area !== exp_da_f(cyc)) begin
            bad++;
            if (first_bad < 0) first_bad = cyc;
         end
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL line_display_area: got %0d bad cycles (first %0d) expected 0", bad, first_bad); end
      n_vec++; if (hfall_q.size() !== 2) begin n_err++; $display("FAIL hsync_fall_count: got %0d expected 2", hfall_q.size()); end
      n_vec++; if (((hfall_q.size() > 0) ? hfall_q[0] : 32'hffff_ffff) !== 32'd658) begin n_err++; $display("FAIL hsync_first_fall: got %0d expected 658", (hfall_q.size() > 0) ? hfall_q[0] : 32'hffff_ffff); end
      n_vec++; if (((hrise_q.size() > 0) ? hrise_q[0] : 32'hffff_ffff) !== 32'd754) begin n_err++; $display("FAIL hsync_low_width_end: got %0d expected 754", (hrise_q.size() > 0) ? hrise_q[0] : 32'hffff_ffff); end
      n_vec++; if (((hfall_q.size() > 1) ? hfall_q[1] : 32'hffff_ffff) !== 32'd1458) begin n_err++; $display("FAIL hsync_period: got %0d expected 1458", (hfall_q.size() > 1) ? hfall_q[1] : 32'hffff_ffff); end
   endtask

   task automatic test_frame_timing();
      int bad = 0;
      int first_bad = -1;
      while (cyc < 2800) begin
         step();
         if (s_display_area !== exp_da_s(cyc) || s_game_enable !== 1'b0 || s_mode !== 2'd0) begin
            bad++;
            if (first_bad < 0) first_bad = cyc;
         end
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL frame_qualifiers: got %0d bad cycles (first %0d) expected 0", bad, first_bad); end
      n_vec++; if (tick_q.size() !== 2) begin n_err++; $display("FAIL tick_count: got %0d expected 2", tick_q.size()); end
      n_vec++; if (((tick_q.size() > 0) ? tick_q[0] : 32'hffff_ffff) !== 32'd960) begin n_err++; $display("FAIL tick_first: got %0d expected 960", (tick_q.size() > 0) ? tick_q[0] : 32'hffff_ffff); end
      n_vec++; if (((tick_q.size() > 1) ? tick_q[1] : 32'hffff_ffff) !== 32'd2560) begin n_err++; $display("FAIL tick_period: got %0d expected 2560", (tick_q.size() > 1) ? tick_q[1] : 32'hffff_ffff); end
      n_vec++; if (((vfall_q.size() > 0) ? vfall_q[0] : 32'hffff_ffff) !== 32'd1122) begin n_err++; $display("FAIL vsync_first_fall: got %0d expected 1122", (vfall_q.size() > 0) ? vfall_q[0] : 32'hffff_ffff); end
      n_vec++; if (((vrise_q.size() > 0) ? vrise_q[0] : 32'hffff_ffff) !== 32'd1282) begin n_err++; $display("FAIL vsync_low_width_end: got %0d expected 1282", (vrise_q.size() > 0) ? vrise_q[0] : 32'hffff_ffff); end
      n_vec++; if (((vfall_q.size() > 1) ? vfall_q[1] : 32'hffff_ffff) !== 32'd2722) begin n_err++; $display("FAIL vsync_period: got %0d expected 2722", (vfall_q.size() > 1) ? vfall_q[1] : 32'hffff_ffff); end
   endtask

   task automatic test_mode_request();
      int bad = 0;
      int ge_cnt = 0;
      run_to(3610);
      n_vec++; if (s_pixel_x !== 10'd10 || s_pixel_y !== 10'd5) begin n_err++; $display("FAIL req_position: got %0d,%0d expected 10,5", s_pixel_x, s_pixel_y); end
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      while (cyc < 4159) begin
         step();
         if (s_mode !== 2'd0 || s_mode_ack !== 1'b0 || s_game_enable !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL title_hold: got %0d bad cycles expected 0", bad); end
      step();
      n_vec++; if (s_mode !== 2'd1) begin n_err++; $display("FAIL title_to_play: got %0d expected 1", s_mode); end
      n_vec++; if (s_mode_ack !== 1'b1 || s_frame_tick !== 1'b1) begin n_err++; $display("FAIL play_ack: got ack=%b tick=%b expected 1/1", s_mode_ack, s_frame_tick); end
      step();
      n_vec++; if (s_mode_ack !== 1'b0) begin n_err++; $display("FAIL play_ack_width: got %b expected 0", s_mode_ack); end
      bad = 0;
      while (cyc < 6400) begin
         step();
         if (s_game_enable !== exp_ge_s(cyc, 1'b1) || s_mode !== 2'd1 || s_mode_ack !== 1'b0) bad++;
         if (cyc > 4800 && s_game_enable === 1'b1) ge_cnt++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL game_window: got %0d bad cycles expected 0", bad); end
      n_vec++; if (ge_cnt !== 192) begin n_err++; $display("FAIL game_window_size: got %0d expected 192", ge_cnt); end
   endtask

   task automatic test_simultaneous();
      int bad = 0;
      run_to(6410);
      start_req = 1'b1;
      over_req = 1'b1;
      step();
      start_req = 1'b0;
      over_req = 1'b0;
      while (cyc < 7359) begin
         step();
         if (s_mode !== 2'd1 || s_mode_ack !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL play_hold: got %0d bad cycles expected 0", bad); end
      step();
      n_vec++; if (s_mode !== 2'd2 || s_mode_ack !== 1'b1) begin n_err++; $display("FAIL play_to_over: got mode=%0d ack=%b expected 2/1", s_mode, s_mode_ack); end
      bad = 0;
      while (cyc < 8961) begin
         step();
         if (s_mode !== 2'd2 || s_mode_ack !== 1'b0 || s_game_enable !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL over_sticks: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_fb_request();
      int bad = 0;
      run_to(10559);
      n_vec++; if (s_pixel_x !== 10'd79 || s_pixel_y !== 10'd11) begin n_err++; $display("FAIL fb_position: got %0d,%0d expected 79,11", s_pixel_x, s_pixel_y); end
      start_req = 1'b1;
      step();
      n_vec++; if (s_mode !== 2'd0 || s_mode_ack !== 1'b1) begin n_err++; $display("FAIL fb_cycle_request: got mode=%0d ack=%b expected 0/1", s_mode, s_mode_ack); end
      step();
      start_req = 1'b0;
      while (cyc < 12159) begin
         step();
         if (s_mode !== 2'd0 || s_mode_ack !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL late_request_waits: got %0d bad cycles expected 0", bad); end
      step();
      n_vec++; if (s_mode !== 2'd1 || s_mode_ack !== 1'b1) begin n_err++; $display("FAIL late_request_applied: got mode=%0d ack=%b expected 1/1", s_mode, s_mode_ack); end
   endtask

   task automatic test_reset_mid();
      run_to(13230);
      n_vec++; if (s_display_area !== 1'b1 || s_game_enable !== 1'b1 || s_pixel_x !== 10'd30) begin n_err++; $display("FAIL pre_reset_state: got da=%b ge=%b x=%0d expected 1/1/30", s_display_area, s_game_enable, s_pixel_x); end
      mon_en = 1'b0;
      #10;
      reset = 1'b1;
      #2;
      n_vec++; if (s_pixel_x !== 10'd0 || s_pixel_y !== 10'd0) begin n_err++; $display("FAIL async_rst_addr: got %0d,%0d expected 0,0", s_pixel_x, s_pixel_y); end
      n_vec++; if (s_display_area !== 1'b0 || s_game_enable !== 1'b0) begin n_err++; $display("FAIL async_rst_qual: got da=%b ge=%b expected 0/0", s_display_area, s_game_enable); end
      n_vec++; if (s_mode !== 2'd0) begin n_err++; $display("FAIL async_rst_mode: got %0d expected 0", s_mode); end
      n_vec++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1 || s_frame_tick !== 1'b0 || s_mode_ack !== 1'b0) begin n_err++; $display("FAIL async_rst_misc: got hs=%b vs=%b tick=%b ack=%b expected 1/1/0/0", s_hsync, s_vsync, s_frame_tick, s_mode_ack); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_vec++; if (s_pixel_x !== 10'd0) begin n_err++; $display("FAIL release_x: got %0d expected 0", s_pixel_x); end
      step();
      n_vec++; if (s_pixel_x !== 10'd1 || s_pixel_y !== 10'd0 || s_mode !== 2'd0) begin n_err++; $display("FAIL restart_count: got x=%0d y=%0d mode=%0d expected 1/0/0", s_pixel_x, s_pixel_y, s_mode); end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_mode_request();
      test_simultaneous();
      test_fb_request();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
